// File: rtl/tx_fifo_serializer.sv
// Transmit FIFO feeding a UART-style serializer: start bit, LSB-first data,
// optional parity, 1-2 stop bits, one bit period per baud_clk cycle.
module tx_fifo_serializer #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                     baud_clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     tx_en,
    input  logic                     rx_ready,
    output logic                     tx_out,
    output logic                     tx_busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop, load_ok, frame_end;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic              par;
    logic [CW-1:0]     bit_cnt;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign push      = wr_en && !full;
    assign load_ok   = tx_en && !empty && rx_ready;
    assign frame_end = (state == STOP) && (bit_cnt == CW'(STOP_BITS - 1));
    // A frame can only be loaded from idle or straight out of its last stop bit.
    assign pop       = load_ok && ((state == IDLE) || frame_end);

    always_ff @(posedge baud_clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            par     <= 1'b0;
            bit_cnt <= '0;
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
        end else if (pop) begin
            state   <= START;
            shreg   <= mem[rd_ptr];
            par     <= (^mem[rd_ptr]) ^ (PARITY_ODD != 0);
            bit_cnt <= '0;
            tx_out  <= 1'b0;
            tx_busy <= 1'b1;
        end else begin
            case (state)
                START: begin
                    state   <= DATA;
                    tx_out  <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (bit_cnt == CW'(DATA_W - 1)) begin
                        bit_cnt <= '0;
                        if (PARITY_EN != 0) begin
                            state  <= PARITY;
                            tx_out <= par;
                        end else begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end
                    end else begin
                        tx_out  <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                PARITY: begin
                    state   <= STOP;
                    tx_out  <= 1'b1;
                    bit_cnt <= '0;
                end
                STOP: begin
                    tx_out <= 1'b1;
                    if (frame_end) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_out  <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tx_fifo_serializer.sv
// Directed bench: expected serial bits are queued per pushed word and popped
// against tx_out each cycle; a second instance covers odd parity / two stops.
module tb_tx_fifo_serializer;
    logic       baud_clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0, tx_en = 1'b0, rx_ready = 1'b0;
    logic [7:0] wr_data = '0;
    logic       tx_out, tx_busy, full, empty, overflow;
    logic [4:0] count;

    logic       wr_en1 = 1'b0, tx_en1 = 1'b0, rx_ready1 = 1'b0;
    logic [7:0] wr_data1 = '0;
    logic       tx_out1, tx_busy1, full1, empty1, overflow1;
    logic [4:0] count1;

    int checks = 0;
    int errors = 0;
    logic q0 [$];
    logic q1 [$];

    always #5 baud_clk = ~baud_clk;

    tx_fifo_serializer dut (
        .baud_clk(baud_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .tx_en(tx_en), .rx_ready(rx_ready), .tx_out(tx_out), .tx_busy(tx_busy),
        .full(full), .empty(empty), .count(count), .overflow(overflow)
    );

    tx_fifo_serializer #(.PARITY_ODD(1), .STOP_BITS(2)) dut1 (
        .baud_clk(baud_clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1),
        .tx_en(tx_en1), .rx_ready(rx_ready1), .tx_out(tx_out1), .tx_busy(tx_busy1),
        .full(full1), .empty(empty1), .count(count1), .overflow(overflow1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge baud_clk);
        #1;
    endtask

    // Expected line bits for one frame: start, data LSB first, parity, stops.
    task automatic exp_frame(input logic [7:0] d, input bit odd, input int stops, input bit sel);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        bits.push_back((^d) ^ odd);
        for (int i = 0; i < stops; i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            if (sel) q1.push_back(bits[i]);
            else     q0.push_back(bits[i]);
        end
    endtask

    task automatic run(input int n, input bit sel);
        logic e;
        for (int i = 0; i < n; i++) begin
            step();
            if ((sel ? q1.size() : q0.size()) == 0) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = sel ? q1.pop_front() : q0.pop_front();
                chk(sel ? "tx_out1_bit" : "tx_out_bit", {31'd0, sel ? tx_out1 : tx_out}, {31'd0, e});
                chk(sel ? "tx_busy1_frame" : "tx_busy_frame", {31'd0, sel ? tx_busy1 : tx_busy}, 32'd1);
            end
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_tx_out", {31'd0, tx_out}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b1;
        step();
        step();
        chk("idle_after_release", {31'd0, tx_out}, 32'd1);

        // Single 0xA5 frame
        tx_en = 1'b1; rx_ready = 1'b1;
        push(8'hA5);
        chk("count_after_push", {27'd0, count}, 32'd1);
        exp_frame(8'hA5, 1'b0, 1, 1'b0);
        run(1, 1'b0);
        chk("empty_after_load", {31'd0, empty}, 32'd1);
        run(10, 1'b0);
        step();
        chk("a5_idle_tx", {31'd0, tx_out}, 32'd1);
        chk("a5_idle_busy", {31'd0, tx_busy}, 32'd0);

        // Fill to full, one dropped push
        tx_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push(8'(i));
            chk("overflow_pulse", {31'd0, overflow}, (i == 16) ? 32'd1 : 32'd0);
            if (i == 15) begin
                chk("count_full", {27'd0, count}, 32'd16);
                chk("full_flag", {31'd0, full}, 32'd1);
            end
        end
        chk("count_after_drop", {27'd0, count}, 32'd16);
        step();
        chk("overflow_clear", {31'd0, overflow}, 32'd0);
        tx_en = 1'b1;
        for (int i = 0; i < 16; i++) exp_frame(8'(i), 1'b0, 1, 1'b0);
        run(176, 1'b0);
        step();
        chk("drain_idle", {31'd0, tx_out}, 32'd1);
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Back-to-back frames
        tx_en = 1'b0;
        push(8'h01);
        push(8'h02);
        tx_en = 1'b1;
        exp_frame(8'h01, 1'b0, 1, 1'b0);
        exp_frame(8'h02, 1'b0, 1, 1'b0);
        run(22, 1'b0);
        step();
        chk("b2b_idle_busy", {31'd0, tx_busy}, 32'd0);

        // rx_ready gating, mid-frame tx_en drop does not abort
        rx_ready = 1'b0;
        push(8'h3C);
        push(8'hC3);
        push(8'h7E);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("blocked_tx_out", {31'd0, tx_out}, 32'd1);
        end
        chk("blocked_count", {27'd0, count}, 32'd3);
        rx_ready = 1'b1;
        exp_frame(8'h3C, 1'b0, 1, 1'b0);
        run(3, 1'b0);
        tx_en = 1'b0;
        run(8, 1'b0);
        step();
        chk("gated_idle_tx", {31'd0, tx_out}, 32'd1);
        chk("gated_idle_busy", {31'd0, tx_busy}, 32'd0);
        chk("gated_count", {27'd0, count}, 32'd2);
        tx_en = 1'b1;
        exp_frame(8'hC3, 1'b0, 1, 1'b0);
        exp_frame(8'h7E, 1'b0, 1, 1'b0);
        run(22, 1'b0);

        // Reset during DATA with two words still queued
        tx_en = 1'b0;
        push(8'h00);
        push(8'h11);
        push(8'h22);
        tx_en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_data_bit", {31'd0, tx_out}, 32'd0);
        chk("pre_rst_count", {27'd0, count}, 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_tx_out", {31'd0, tx_out}, 32'd1);
        chk("async_rst_count", {27'd0, count}, 32'd0);
        chk("async_rst_empty", {31'd0, empty}, 32'd1);
        chk("async_rst_busy", {31'd0, tx_busy}, 32'd0);
        step();
        step();
        #3 rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("post_rst_quiet", {30'd0, tx_busy, tx_out}, 32'd1);
        end

        // Odd parity, two stop bits
        tx_en = 1'b0;
        wr_en1 = 1'b1; wr_data1 = 8'h00;
        step();
        wr_en1 = 1'b0;
        tx_en1 = 1'b1; rx_ready1 = 1'b1;
        exp_frame(8'h00, 1'b1, 2, 1'b1);
        run(12, 1'b1);
        step();
        chk("odd_idle_tx", {31'd0, tx_out1}, 32'd1);
        chk("odd_idle_busy", {31'd0, tx_busy1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_fifo_serializer.md
TX_FIFO_SERIALIZER -- requirements
Module: tx_fifo_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter PARITY_EN, default 1, 1 = parity bit appended after data.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-006 SHALL have port baud_clk  input  1  single clock, one bit period per cycle, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port wr_en  input  1  push request.
REQ-009 SHALL have port wr_data  input  DATA_W  word to push.
REQ-010 SHALL have port tx_en  input  1  permission to start new frames.
REQ-011 SHALL have port rx_ready  input  1  receiver-side ready, sampled only at frame start.
REQ-012 SHALL have port tx_out  output  1  registered serial line, idle high.
REQ-013 SHALL have port tx_busy  output  1  high while a frame is on the line.
REQ-014 SHALL have port full  output  1  count == DEPTH.
REQ-015 SHALL have port empty  output  1  count == 0.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  entries stored.
REQ-017 SHALL have port overflow  output  1  one-cycle pulse on a dropped push.

Function
REQ-018 Push SHALL occur at the edge where wr_en=1 and full=0; wr_data written at write pointer, pointer wraps DEPTH-1 -> 0.
REQ-019 wr_en=1 with full=1 SHALL drop the word, leave memory/pointers unchanged, and pulse overflow for one cycle, even if a pop occurs on the same edge.
REQ-020 Pop SHALL occur only on frame load (REQ-023); read pointer wraps DEPTH-1 -> 0.
REQ-021 Push and pop on the same edge SHALL leave count unchanged; a push into an empty FIFO SHALL not be popped on that edge.
REQ-022 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-023 Frame load condition = tx_en=1 and empty=0 and rx_ready=1; on load the head word SHALL be popped into a shift register and the FSM SHALL enter START.
REQ-024 IDLE: tx_out=1, tx_busy=0; transition to START on load condition.
REQ-025 START: tx_out=0 for 1 cycle -> DATA.
REQ-026 DATA: DATA_W cycles, LSB first -> PARITY if PARITY_EN=1, else STOP.
REQ-027 PARITY: 1 cycle, tx_out = XOR of data bits, inverted when PARITY_ODD=1 -> STOP.
REQ-028 STOP: STOP_BITS cycles of tx_out=1; after the last, START if load condition holds (back-to-back, no idle bit), else IDLE.
REQ-029 tx_out and tx_busy SHALL be registered and change on the same edge as the state; frame length = 1+DATA_W+PARITY_EN+STOP_BITS cycles.
REQ-030 tx_en or rx_ready deasserting mid-frame SHALL not abort the frame; it only blocks the next load.
REQ-031 full, empty, count SHALL reflect the post-edge contents.

Reset
REQ-032 rst=0 SHALL immediately force: state IDLE, pointers 0, count 0, empty 1, full 0, tx_out 1, tx_busy 0, overflow 0; memory contents not reset; a frame in flight is abandoned and queued data lost.
REQ-033 After rst release, no frame SHALL start before the first edge with the load condition true.

Verification
REQ-034 Defaults, push 0xA5, tx_en=rx_ready=1 -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1 (11 cycles), then idle 1; empty=1 after load.
REQ-035 Defaults, tx_en=0, 17 pushes 0x00..0x10 -> count=16, full=1, overflow pulses once on 17th; later frames carry 0x00..0x0F only.
REQ-036 Defaults, push 0x01 and 0x02, tx_en=1 -> 22 consecutive frame cycles, second start bit immediately follows first stop bit, tx_busy high throughout.
REQ-037 rx_ready=0 with 3 queued words, tx_en=1 -> tx_out stays 1, count=3; raise rx_ready -> start bit on next cycle.
REQ-038 PARITY_ODD=1, STOP_BITS=2, push 0x00 -> tx_out 0,0,0,0,0,0,0,0,0,1,1,1 (12 cycles).
REQ-039 rst=0 during DATA of a frame with 2 more queued -> tx_out=1, count=0, empty=1 without waiting for an edge; no further frames after release.
